// File: rtl/send_data.sv
// Pattern transmitter: after start, streams word_count words of the chosen pattern over valid/ready.
// First word is valid two cycles after start; dout/dout_valid hold while dout_ready is low.
module send_data #(
  parameter int          COUNT_WIDTH = 32,
  parameter logic [31:0] LFSR_TAPS   = 32'h80200003
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             pattern_sel,
  input  logic [31:0]            pattern_seed,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic                   inject_error,
  output logic [31:0]            dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] words_sent
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] C_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] C_ZERO = '0;

  logic [1:0]             r_state;
  logic [1:0]             r_sel;
  logic [31:0]            r_seed;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [31:0]            r_gen;
  logic                   r_dout_valid;
  logic [COUNT_WIDTH-1:0] r_words_sent;

  logic                   w_hs;
  logic                   w_last;
  logic [31:0]            w_next;
  logic [31:0]            w_load_val;

  assign w_hs   = r_dout_valid & dout_ready;
  // Exact compare against count-1 so a full-scale count never wraps early.
  assign w_last = (r_words_sent == (r_count - C_ONE));

  // An all-zero LFSR state would lock up, so seed 0 is promoted to 1.
  assign w_load_val = ((r_sel == 2'd2) && (r_seed == 32'd0)) ? 32'd1 : r_seed;

  always_comb begin
    w_next = r_gen;
    case (r_sel)
      2'd0:    w_next = r_gen + 32'd1;
      2'd1:    w_next = {r_gen[30:0], r_gen[31]};
      2'd2:    w_next = r_gen[0] ? ((r_gen >> 1) ^ LFSR_TAPS) : (r_gen >> 1);
      default: w_next = r_gen;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sel        <= 2'd0;
      r_seed       <= 32'd0;
      r_count      <= C_ZERO;
      r_gen        <= 32'd0;
      r_dout_valid <= 1'b0;
      r_words_sent <= C_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sel        <= pattern_sel;
            r_seed       <= pattern_seed;
            r_count      <= word_count;
            r_words_sent <= C_ZERO;
            r_state      <= (word_count == C_ZERO) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_state <= S_DONE;
          end else begin
            r_gen        <= w_load_val;
            r_dout_valid <= 1'b1;
            r_state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            r_words_sent <= r_words_sent + C_ONE;
            r_gen        <= w_next;
          end
          if (abort || (w_hs && w_last)) begin
            r_dout_valid <= 1'b0;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Injection flips only the presented word; the generator sequence is untouched.
  assign dout       = r_gen ^ {31'd0, inject_error & r_dout_valid};
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state == S_LOAD) || (r_state == S_SEND);
  assign done       = (r_state == S_DONE);
  assign words_sent = r_words_sent;

endmodule

// File: tb/tb_send_data.sv
// Bench for send_data: directed vector table, hand-written reset sequences, and randomized
// transfers checked against a pattern model computed directly from the sequence definitions.
module tb_send_data;

  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [31:0] pattern_seed = 32'd0;
  logic [31:0] word_count = 32'd0;
  logic        inject_error = 1'b0;
  logic        dout_ready = 1'b0;
  logic [31:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        done;
  logic [31:0] words_sent;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] q[$];
  int acc, first_v, done_c, abort_c, n_start;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] seed;
    logic [31:0] cnt;
    int          rmode;
    int          inj;
    int          abort_at;
    bit          abort_rdy;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    int          sent;
    int          errs;
  } vec_t;

  vec_t tbl[10];

  send_data dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern_sel(pattern_sel), .pattern_seed(pattern_seed), .word_count(word_count),
    .inject_error(inject_error), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .done(done), .words_sent(words_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word k of a sequence, from the closed-form definition of each pattern.
  function automatic logic [31:0] model(input logic [1:0] sel, input logic [31:0] seed, input int k);
    logic [31:0] s;
    int r;
    case (sel)
      2'd0: model = seed + 32'(k);
      2'd1: begin
        r = k % 32;
        model = (r == 0) ? seed : ((seed << r) | (seed >> (32 - r)));
      end
      2'd2: begin
        s = (seed == 32'd0) ? 32'd1 : seed;
        for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
        model = s;
      end
      default: model = seed;
    endcase
  endfunction

  // Called just after a rising edge with the DUT idle; returns after the IDLE edge following done.
  task automatic run_xfer(input logic [1:0] sel, input logic [31:0] seed, input logic [31:0] cnt,
                          input int rmode, input int inj, input int abort_at, input bit abort_rdy);
    int limit, it;
    bit fin, aborted, prev_stall;
    logic [31:0] prev_dout;
    limit = int'(cnt) * 4 + 40;
    it = 0; fin = 0; aborted = 0; prev_stall = 0; prev_dout = 32'd0;
    q.delete(); acc = 0; first_v = -1; done_c = -1; abort_c = -1;
    pattern_sel = sel; pattern_seed = seed; word_count = cnt;
    start = 1'b1; n_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    pattern_sel = ~sel; pattern_seed = ~seed; word_count = cnt + 32'd7;
    while (!fin && it < limit) begin
      case (rmode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = (it % 2 == 0);
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      inject_error = (acc == inj);
      if (abort_at >= 0 && !aborted && acc == abort_at) begin
        abort = 1'b1; dout_ready = abort_rdy; aborted = 1; abort_c = cyc;
      end
      @(negedge clk);
      if (it == 0) begin
        check("busy_after_start", 32'(busy), 32'(cnt != 32'd0));
        check("sent_cleared", words_sent, 32'd0);
      end
      if (prev_stall) begin
        check("hold_valid", 32'(dout_valid), 32'd1);
        check("hold_data", dout, prev_dout);
      end
      if (dout_valid && first_v < 0) first_v = cyc;
      prev_stall = dout_valid & ~dout_ready & ~abort;
      prev_dout = dout;
      if (dout_valid && dout_ready) begin
        q.push_back(dout);
        acc++;
      end
      if (done) begin
        done_c = cyc;
        check("busy_in_done", 32'(busy), 32'd0);
        check("valid_in_done", 32'(dout_valid), 32'd0);
        fin = 1;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      it++;
    end
    dout_ready = 1'b0; inject_error = 1'b0; abort = 1'b0;
    check("done_seen", 32'(fin), 32'd1);
  endtask

  task automatic verify(input logic [1:0] sel, input logic [31:0] seed, input logic [31:0] cnt,
                        input int rmode, input int inj, input int abort_at,
                        input int exp_sent, input int exp_errs);
    int errs;
    logic [31:0] clean;
    errs = 0;
    check("words_sent", words_sent, 32'(exp_sent));
    check("accepted", 32'(acc), 32'(exp_sent));
    check("done_one_cycle", 32'(done), 32'd0);
    for (int k = 0; k < q.size(); k++) begin
      clean = model(sel, seed, k);
      if (q[k] !== clean) errs++;
      check("word", q[k], clean ^ 32'(k == inj));
    end
    check("far_end_errors", 32'(errs), 32'(exp_errs));
    if (abort_at >= 0) begin
      check("abort_done_lat", 32'(done_c), 32'(abort_c + 1));
    end else if (cnt == 32'd0) begin
      check("zero_done_lat", 32'(done_c), 32'(n_start + 1));
      check("zero_no_valid", 32'(first_v < 0), 32'd1);
    end else if (rmode == 0) begin
      check("first_valid_lat", 32'(first_v), 32'(n_start + 2));
      check("done_lat", 32'(done_c), 32'(n_start + 2 + int'(cnt)));
    end
  endtask

  initial begin
    logic [31:0] wexp[3];
    logic [1:0]  rsel;
    logic [31:0] rseed, rcnt;
    int          rinj;

    //            sel   seed           cnt    rmode inj abort rdy  w0            w1            w2            sent errs
    tbl[0] = '{2'd0, 32'hFFFFFFFE, 32'd4,  0, -1, -1, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 4,  0};
    tbl[1] = '{2'd1, 32'h00000001, 32'd33, 0, -1, -1, 1'b0, 32'h00000001, 32'h00000002, 32'h00000004, 33, 0};
    tbl[2] = '{2'd3, 32'hA5A5A5A5, 32'd3,  0, -1, -1, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 3,  0};
    tbl[3] = '{2'd2, 32'h00000000, 32'd3,  0, -1, -1, 1'b0, 32'h00000001, 32'h80200003, 32'hC0300002, 3,  0};
    tbl[4] = '{2'd2, 32'h00000000, 32'd3,  1, -1, -1, 1'b0, 32'h00000001, 32'h80200003, 32'hC0300002, 3,  0};
    tbl[5] = '{2'd0, 32'h00000000, 32'd5,  0,  2, -1, 1'b0, 32'h00000000, 32'h00000001, 32'h00000003, 5,  1};
    tbl[6] = '{2'd0, 32'h00000005, 32'd0,  0, -1, -1, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 0,  0};
    tbl[7] = '{2'd0, 32'h00000000, 32'd10, 0, -1,  2, 1'b0, 32'h00000000, 32'h00000001, 32'h00000000, 2,  0};
    tbl[8] = '{2'd0, 32'h00000000, 32'd10, 0, -1,  3, 1'b1, 32'h00000000, 32'h00000001, 32'h00000002, 4,  0};
    tbl[9] = '{2'd1, 32'h80000000, 32'd2,  1, -1, -1, 1'b0, 32'h80000000, 32'h00000001, 32'h00000000, 2,  0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout, 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_words_sent", words_sent, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      run_xfer(tbl[v].sel, tbl[v].seed, tbl[v].cnt, tbl[v].rmode, tbl[v].inj,
               tbl[v].abort_at, tbl[v].abort_rdy);
      verify(tbl[v].sel, tbl[v].seed, tbl[v].cnt, tbl[v].rmode, tbl[v].inj,
             tbl[v].abort_at, tbl[v].sent, tbl[v].errs);
      wexp = '{tbl[v].w0, tbl[v].w1, tbl[v].w2};
      for (int k = 0; k < 3 && k < q.size(); k++) check("vec_word", q[k], wexp[k]);
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of SEND clears outputs without a clock edge.
    pattern_sel = 2'd0; pattern_seed = 32'h00000100; word_count = 32'd10;
    dout_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_valid", 32'(dout_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_dout", dout, 32'd0);
    check("arst_valid", 32'(dout_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_words_sent", words_sent, 32'd0);
    @(negedge clk);
    reset = 1'b0; dout_ready = 1'b0;
    @(posedge clk); #1;
    check("post_reset_no_done", 32'(done), 32'd0);
    @(posedge clk); #1;

    for (int r = 0; r < 20; r++) begin
      rsel  = 2'($urandom_range(0, 3));
      rseed = (r % 5 == 0) ? 32'd0 : $urandom;
      rcnt  = 32'($urandom_range(1, 40));
      rinj  = $urandom_range(0, int'(rcnt));
      run_xfer(rsel, rseed, rcnt, 2, rinj, -1, 1'b0);
      verify(rsel, rseed, rcnt, 2, rinj, -1, int'(rcnt), (rinj < int'(rcnt)) ? 1 : 0);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
